// File: rtl/tecl_pkg.sv
// Shared types and constants for the PS/2 scan-code controller.
package tecl_pkg;

  // Event word is {ext, rel, code}
  localparam int unsigned EVT_W = 10;

  // Prefix bytes
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // Keyboard status / reply bytes that never form key events
  localparam logic [7:0] SC_IGN_ZERO = 8'h00;
  localparam logic [7:0] SC_IGN_BAT  = 8'hAA;
  localparam logic [7:0] SC_IGN_ECHO = 8'hEE;
  localparam logic [7:0] SC_IGN_ACK  = 8'hFA;
  localparam logic [7:0] SC_IGN_RSND = 8'hFE;
  localparam logic [7:0] SC_IGN_ERR  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_E0   = 2'd1,
    ST_GOT_F0   = 2'd2,
    ST_GOT_E0F0 = 2'd3
  } scan_state_e;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } scan_evt_t;

  function automatic logic is_ignored(input logic [7:0] code);
    case (code)
      SC_IGN_ZERO, SC_IGN_BAT, SC_IGN_ECHO,
      SC_IGN_ACK, SC_IGN_RSND, SC_IGN_ERR: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic scan_evt_t pack_evt(input logic ext, input logic rel,
                                         input logic [7:0] code);
    scan_evt_t e;
    e.ext  = ext;
    e.rel  = rel;
    e.code = code;
    return e;
  endfunction

endpackage

// File: rtl/tecl_evt_fifo.sv
// Synchronous event FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module tecl_evt_fifo
  import tecl_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [EVT_W-1:0] din_i,
  input  logic             pop_i,
  output logic [EVT_W-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_nxt_o
);

  logic [EVT_W-1:0] mem_q [DEPTH];
  logic [EVT_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Head is forced to zero while empty so stale words never reach the outputs
  assign dout_o      = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_nxt_o = cnt_d;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/tecl_scan_ctrl.sv
// PS/2 scan-code controller: parity check, prefix assembly, timeout and
// buffered key-event output over valid/ready.
module tecl_scan_ctrl
  import tecl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_listo_i,
  input  logic [7:0] code_i,
  input  logic       par_i,
  output logic       rx_en_o,
  output logic       ev_valid_o,
  input  logic       ev_ready_i,
  output logic [7:0] ev_code_o,
  output logic       ev_ext_o,
  output logic       ev_rel_o,
  output logic       parity_err_o,
  output logic       proto_err_o,
  output logic       timeout_err_o,
  output logic       ovf_err_o
);

  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  // The counter fires on the cycle it would step to TIMEOUT_CYC-1, which puts
  // the registered pulse exactly TIMEOUT_CYC cycles after the prefix byte.
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 2);

  scan_state_e   state_q, state_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          parity_err_q, parity_err_d;
  logic          proto_err_q, proto_err_d;
  logic          timeout_err_q, timeout_err_d;
  logic          ovf_err_q, ovf_err_d;
  logic          rx_en_q, rx_en_d;

  logic          push;
  scan_evt_t     push_evt;
  scan_evt_t     head_evt;
  logic          pop;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_cnt_nxt;
  logic          par_ok;

  assign par_ok = ^{code_i, par_i};
  assign pop    = ~fifo_empty & ev_ready_i;

  tecl_evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .din_i       (push_evt),
    .pop_i       (pop),
    .dout_o      (head_evt),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_nxt_o (fifo_cnt_nxt)
  );

  // Prefix FSM, parity check and prefix timeout
  always_comb begin
    state_d       = state_q;
    tmo_cnt_d     = tmo_cnt_q;
    push          = 1'b0;
    push_evt      = '0;
    parity_err_d  = 1'b0;
    proto_err_d   = 1'b0;
    timeout_err_d = 1'b0;
    if (rx_listo_i) begin
      tmo_cnt_d = '0;
      if (!par_ok) begin
        parity_err_d = 1'b1;
        state_d      = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (code_i == SC_EXT) begin
              state_d = ST_GOT_E0;
            end else if (code_i == SC_BRK) begin
              state_d = ST_GOT_F0;
            end else if (!is_ignored(code_i)) begin
              push     = 1'b1;
              push_evt = pack_evt(1'b0, 1'b0, code_i);
            end
          end
          ST_GOT_E0: begin
            if (code_i == SC_EXT) begin
              state_d = ST_GOT_E0;
            end else if (code_i == SC_BRK) begin
              state_d = ST_GOT_E0F0;
            end else begin
              push     = 1'b1;
              push_evt = pack_evt(1'b1, 1'b0, code_i);
              state_d  = ST_IDLE;
            end
          end
          ST_GOT_F0: begin
            if (code_i == SC_BRK) begin
              state_d = ST_GOT_F0;
            end else if (code_i == SC_EXT) begin
              proto_err_d = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              push     = 1'b1;
              push_evt = pack_evt(1'b0, 1'b1, code_i);
              state_d  = ST_IDLE;
            end
          end
          ST_GOT_E0F0: begin
            if (code_i == SC_EXT || code_i == SC_BRK) begin
              proto_err_d = 1'b1;
            end else begin
              push     = 1'b1;
              push_evt = pack_evt(1'b1, 1'b1, code_i);
            end
            state_d = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end else if (state_q != ST_IDLE) begin
      if (tmo_cnt_q == TMO_LAST) begin
        timeout_err_d = 1'b1;
        state_d       = ST_IDLE;
        tmo_cnt_d     = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
      end
    end else begin
      tmo_cnt_d = '0;
    end
  end

  // Overflow detection and receiver throttle
  always_comb begin
    ovf_err_d = push & fifo_full & ~pop;
    rx_en_d   = (fifo_cnt_nxt < CW'(FIFO_DEPTH));
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      tmo_cnt_q     <= '0;
      parity_err_q  <= 1'b0;
      proto_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      ovf_err_q     <= 1'b0;
      rx_en_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_cnt_q     <= tmo_cnt_d;
      parity_err_q  <= parity_err_d;
      proto_err_q   <= proto_err_d;
      timeout_err_q <= timeout_err_d;
      ovf_err_q     <= ovf_err_d;
      rx_en_q       <= rx_en_d;
    end
  end

  assign rx_en_o       = rx_en_q;
  assign ev_valid_o    = ~fifo_empty;
  assign ev_code_o     = head_evt.code;
  assign ev_ext_o      = head_evt.ext;
  assign ev_rel_o      = head_evt.rel;
  assign parity_err_o  = parity_err_q;
  assign proto_err_o   = proto_err_q;
  assign timeout_err_o = timeout_err_q;
  assign ovf_err_o     = ovf_err_q;

endmodule

// File: tb/tb_tecl_scan_ctrl.sv
// Self-checking bench for tecl_scan_ctrl: byte vector table, scoreboard of
// expected events, and hand sequences for timeout, overflow and reset.
module tb_tecl_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_i;
  logic       rx_listo_i;
  logic [7:0] code_i;
  logic       par_i;
  logic       rx_en_o;
  logic       ev_valid_o;
  logic       ev_ready_i;
  logic [7:0] ev_code_o;
  logic       ev_ext_o;
  logic       ev_rel_o;
  logic       parity_err_o;
  logic       proto_err_o;
  logic       timeout_err_o;
  logic       ovf_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [9:0] sb_q[$];
  logic [9:0] sb_exp;

  typedef struct {
    logic [7:0] code;
    bit         ok;
    bit         ev;
    bit         ext;
    bit         rel;
    bit         perr;
    bit         prerr;
  } vec_t;

  vec_t vt[$];

  always #5 clk = ~clk;

  tecl_scan_ctrl #(
    .TIMEOUT_CYC (16),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .rx_listo_i    (rx_listo_i),
    .code_i        (code_i),
    .par_i         (par_i),
    .rx_en_o       (rx_en_o),
    .ev_valid_o    (ev_valid_o),
    .ev_ready_i    (ev_ready_i),
    .ev_code_o     (ev_code_o),
    .ev_ext_o      (ev_ext_o),
    .ev_rel_o      (ev_rel_o),
    .parity_err_o  (parity_err_o),
    .proto_err_o   (proto_err_o),
    .timeout_err_o (timeout_err_o),
    .ovf_err_o     (ovf_err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one byte for exactly one cycle; returns #1 after the capturing edge
  task automatic pulse_byte(input logic [7:0] c, input bit ok);
    rx_listo_i = 1'b1;
    code_i     = c;
    par_i      = ok ? ~(^c) : (^c);
    @(posedge clk);
    #1;
    rx_listo_i = 1'b0;
    par_i      = 1'b0;
  endtask

  task automatic send(input logic [7:0] c, input bit ok);
    @(posedge clk);
    #1;
    pulse_byte(c, ok);
  endtask

  // Scoreboard: every handshake must match the oldest expected event
  always @(negedge clk) begin
    if (!rst_i && ev_valid_o && ev_ready_i) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got %0h expected no event",
                 {ev_ext_o, ev_rel_o, ev_code_o});
      end else begin
        sb_exp = sb_q.pop_front();
        chk("sb_event", {22'b0, ev_ext_o, ev_rel_o, ev_code_o}, {22'b0, sb_exp});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected test completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    logic [7:0] ovf_codes [5];
    rst_i      = 1'b1;
    rx_listo_i = 1'b0;
    code_i     = '0;
    par_i      = 1'b0;
    ev_ready_i = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", {ev_valid_o, rx_en_o, ev_code_o, ev_ext_o, ev_rel_o,
                        parity_err_o, proto_err_o, timeout_err_o, ovf_err_o}, '0);
    rst_i = 1'b0;
    chk("rst_rx_en_low", rx_en_o, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_rx_en_rise", rx_en_o, 1'b1);

    // First make code: visible the cycle after, gone one cycle later
    sb_q.push_back({2'b00, 8'h1C});
    send(8'h1C, 1'b1);
    chk("first_valid", ev_valid_o, 1'b1);
    chk("first_code", ev_code_o, 8'h1C);
    @(posedge clk);
    #1;
    chk("first_popped", ev_valid_o, 1'b0);

    // Byte vector table
    vt.push_back('{8'h1C, 1, 1, 0, 0, 0, 0});
    vt.push_back('{8'hF0, 1, 0, 0, 0, 0, 0});
    vt.push_back('{8'h1C, 1, 1, 0, 1, 0, 0});
    vt.push_back('{8'hE0, 1, 0, 0, 0, 0, 0});
    vt.push_back('{8'hF0, 1, 0, 0, 0, 0, 0});
    vt.push_back('{8'h75, 1, 1, 1, 1, 0, 0});
    vt.push_back('{8'hE0, 1, 0, 0, 0, 0, 0});
    vt.push_back('{8'hF0, 0, 0, 0, 0, 1, 0});
    vt.push_back('{8'h1C, 1, 1, 0, 0, 0, 0});
    vt.push_back('{8'hF0, 1, 0, 0, 0, 0, 0});
    vt.push_back('{8'hE0, 1, 0, 0, 0, 0, 1});
    vt.push_back('{8'h1C, 1, 1, 0, 0, 0, 0});
    vt.push_back('{8'hAA, 1, 0, 0, 0, 0, 0});
    vt.push_back('{8'hFF, 1, 0, 0, 0, 0, 0});
    vt.push_back('{8'h00, 1, 0, 0, 0, 0, 0});
    vt.push_back('{8'hFA, 1, 0, 0, 0, 0, 0});
    vt.push_back('{8'hE0, 1, 0, 0, 0, 0, 0});
    vt.push_back('{8'hE0, 1, 0, 0, 0, 0, 0});
    vt.push_back('{8'h74, 1, 1, 1, 0, 0, 0});
    vt.push_back('{8'hF0, 1, 0, 0, 0, 0, 0});
    vt.push_back('{8'hF0, 1, 0, 0, 0, 0, 0});
    vt.push_back('{8'h1C, 1, 1, 0, 1, 0, 0});
    vt.push_back('{8'hE0, 1, 0, 0, 0, 0, 0});
    vt.push_back('{8'hF0, 1, 0, 0, 0, 0, 0});
    vt.push_back('{8'hE0, 1, 0, 0, 0, 0, 1});
    vt.push_back('{8'h5A, 1, 1, 0, 0, 0, 0});
    vt.push_back('{8'hE0, 1, 0, 0, 0, 0, 0});
    vt.push_back('{8'hF0, 1, 0, 0, 0, 0, 0});
    vt.push_back('{8'hF0, 1, 0, 0, 0, 0, 1});
    vt.push_back('{8'h1C, 0, 0, 0, 0, 1, 0});
    vt.push_back('{8'hE0, 1, 0, 0, 0, 0, 0});
    vt.push_back('{8'hAA, 1, 1, 1, 0, 0, 0});

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].ev) sb_q.push_back({vt[i].ext, vt[i].rel, vt[i].code});
      send(vt[i].code, vt[i].ok);
      chk($sformatf("v%0d_valid", i), ev_valid_o, vt[i].ev);
      if (vt[i].ev) begin
        chk($sformatf("v%0d_event", i), {ev_ext_o, ev_rel_o, ev_code_o},
            {vt[i].ext, vt[i].rel, vt[i].code});
      end
      chk($sformatf("v%0d_parity_err", i), parity_err_o, vt[i].perr);
      chk($sformatf("v%0d_proto_err", i), proto_err_o, vt[i].prerr);
      chk($sformatf("v%0d_other_err", i), {timeout_err_o, ovf_err_o}, 2'b00);
    end

    // Prefix timeout: pulse lands 16 cycles after the E0 was accepted
    send(8'hE0, 1'b1);
    chk("tmo_c1", timeout_err_o, 1'b0);
    for (int i = 2; i <= 20; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("tmo_c%0d", i), timeout_err_o, (i == 16));
    end
    sb_q.push_back({2'b00, 8'h1C});
    send(8'h1C, 1'b1);
    chk("tmo_after_valid", ev_valid_o, 1'b1);
    chk("tmo_after_ext", ev_ext_o, 1'b0);

    // Fill, overflow, throttle and drain
    ovf_codes[0] = 8'h15;
    ovf_codes[1] = 8'h1D;
    ovf_codes[2] = 8'h24;
    ovf_codes[3] = 8'h2D;
    ovf_codes[4] = 8'h2C;
    @(posedge clk);
    #1;
    ev_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) sb_q.push_back({2'b00, ovf_codes[i]});
      send(ovf_codes[i], 1'b1);
      chk($sformatf("fill%0d_rx_en", i), rx_en_o, (i < 3));
      chk($sformatf("fill%0d_ovf", i), ovf_err_o, (i == 4));
    end
    @(posedge clk);
    #1;
    chk("ovf_one_cycle", ovf_err_o, 1'b0);
    chk("full_head_stable", ev_code_o, 8'h15);
    ev_ready_i = 1'b1;
    chk("pop_rx_en_before", rx_en_o, 1'b0);
    @(posedge clk);
    #1;
    ev_ready_i = 1'b0;
    chk("pop_rx_en_rise", rx_en_o, 1'b1);
    chk("pop_next_head", ev_code_o, 8'h1D);
    sb_q.push_back({2'b00, 8'h3C});
    send(8'h3C, 1'b1);
    chk("refill_rx_en", rx_en_o, 1'b0);
    chk("refill_ovf", ovf_err_o, 1'b0);
    @(posedge clk);
    #1;
    ev_ready_i = 1'b1;
    sb_q.push_back({2'b00, 8'h4B});
    pulse_byte(8'h4B, 1'b1);
    chk("pushpop_ovf", ovf_err_o, 1'b0);
    chk("pushpop_rx_en", rx_en_o, 1'b0);
    for (int k = 0; k < 20 && sb_q.size() != 0; k++) @(posedge clk);
    @(posedge clk);
    #1;
    chk("drain_empty", sb_q.size(), 0);
    chk("drain_valid", ev_valid_o, 1'b0);
    chk("drain_rx_en", rx_en_o, 1'b1);

    // Reset in the middle of a prefix
    send(8'hE0, 1'b1);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_outputs", {ev_valid_o, rx_en_o, ev_code_o, ev_ext_o, ev_rel_o,
                           parity_err_o, proto_err_o, timeout_err_o, ovf_err_o}, '0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_rx_en", rx_en_o, 1'b1);
    sb_q.push_back({2'b00, 8'h1C});
    send(8'h1C, 1'b1);
    chk("midrst_event", {ev_valid_o, ev_ext_o, ev_rel_o, ev_code_o}, {3'b100, 8'h1C});

    repeat (3) @(posedge clk);
    #1;
    chk("final_sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
